// File: rtl/direction_accumulator.sv
// Frame-level direction-of-arrival accumulator: per bin it weights wrapped mic phase differences by
// mic location, scales them by the central magnitude and accumulates a {y, x} vector over a frame.
module direction_accumulator #(
  parameter int NUM_PERIPH = 3,
  parameter int MAX_BINS   = 16,
  parameter logic [2*NUM_PERIPH-1:0] X_COEF = 6'b01_11_00,
  parameter logic [2*NUM_PERIPH-1:0] Y_COEF = 6'b11_11_01
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [31:0]             central_mic_in,
  input  logic [32*NUM_PERIPH-1:0] peripheral_mics_in,
  input  logic                    data_valid_in,
  input  logic                    data_last_in,
  output logic                    data_ready_out,
  output logic [31:0]             vector_out,
  output logic                    vector_valid_out,
  input  logic                    vector_ready_in,
  output logic                    overflow_out
);

  localparam int IW = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
  localparam int SW = 16 + $clog2(NUM_PERIPH) + 1;
  localparam int PW = SW + 16;
  localparam int AW = PW + $clog2(MAX_BINS);
  localparam int BW = $clog2(MAX_BINS) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PERIPH - 1);
  localparam logic [BW-1:0] BIN_MAX  = BW'(MAX_BINS);
  localparam logic signed [AW+15:0] SAT_MAX = (AW+16)'(32'sd32767);
  localparam logic signed [AW+15:0] SAT_MIN = (AW+16)'(-32'sd32768);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUM    = 2'd1,
    SCALE  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // Phase difference folded back into [-pi, +pi]; exactly +/-pi is left alone.
  function automatic logic signed [15:0] wrap_diff(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
    logic signed [16:0] d;
    d = 17'(a) - 17'(b);
    if (d > 17'sh06488) begin
      d = d - 17'sh0C910;
    end else if (d < -17'sh06488) begin
      d = d + 17'sh0C910;
    end else begin
      d = d;
    end
    return d[15:0];
  endfunction

  function automatic logic [15:0] sat16(input logic signed [AW-1:0] a);
    logic signed [AW+15:0] w;
    w = (AW+16)'(a);
    w = w >>> 5'd18;
    if (w > SAT_MAX) begin
      return 16'h7FFF;
    end else if (w < SAT_MIN) begin
      return 16'h8000;
    end else begin
      return w[15:0];
    end
  endfunction

  state_t                  state_r, state_nxt_s;
  logic signed [15:0]      central_phase_r, central_mag_r;
  logic signed [15:0]      phase_r [NUM_PERIPH];
  logic                    last_r;
  logic [IW-1:0]           idx_r;
  logic signed [SW-1:0]    sum_x_r, sum_y_r, term_x_s, term_y_s;
  logic signed [PW-1:0]    prod_x_s, prod_y_s;
  logic signed [AW-1:0]    acc_x_r, acc_y_r, acc_x_nxt_s, acc_y_nxt_s;
  logic [BW-1:0]           bin_cnt_r, bin_nxt_s;
  logic [31:0]             vector_r;
  logic                    ready_r, valid_r, overflow_r;
  logic                    ready_nxt_s, valid_nxt_s;
  logic                    accept_s, handshake_s, close_s;
  logic signed [15:0]      diff_s;
  logic [1:0]              coef_x_s, coef_y_s;
  logic [16*NUM_PERIPH-1:0] unused_mags_s;

  assign accept_s    = data_valid_in && ready_r && (state_r == IDLE);
  assign handshake_s = valid_r && vector_ready_in;
  assign diff_s      = wrap_diff(phase_r[idx_r], central_phase_r);
  assign coef_x_s    = X_COEF[{idx_r, 1'b0} +: 2];
  assign coef_y_s    = Y_COEF[{idx_r, 1'b0} +: 2];
  assign prod_x_s    = PW'(sum_x_r) * PW'(central_mag_r);
  assign prod_y_s    = PW'(sum_y_r) * PW'(central_mag_r);
  assign acc_x_nxt_s = acc_x_r + AW'(prod_x_s);
  assign acc_y_nxt_s = acc_y_r + AW'(prod_y_s);
  assign bin_nxt_s   = bin_cnt_r + BW'(1'b1);
  assign close_s     = last_r || (bin_nxt_s == BIN_MAX);

  // Peripheral magnitudes take no part in the direction estimate.
  always_comb begin
    unused_mags_s = {(16*NUM_PERIPH){1'b0}};
    for (int i = 0; i < NUM_PERIPH; i++) begin
      unused_mags_s[16*i +: 16] = peripheral_mics_in[32*i +: 16];
    end
  end

  // Location weighting: coefficient +1 adds, -1 subtracts, 0 contributes nothing.
  always_comb begin
    term_x_s = {SW{1'b0}};
    term_y_s = {SW{1'b0}};
    case (coef_x_s)
      2'b01:   term_x_s = SW'(diff_s);
      2'b11:   term_x_s = -SW'(diff_s);
      default: term_x_s = {SW{1'b0}};
    endcase
    case (coef_y_s)
      2'b01:   term_y_s = SW'(diff_s);
      2'b11:   term_y_s = -SW'(diff_s);
      default: term_y_s = {SW{1'b0}};
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_nxt_s = SUM; else state_nxt_s = IDLE;
      SUM:     if (idx_r == LAST_IDX) state_nxt_s = SCALE; else state_nxt_s = SUM;
      SCALE:   if (close_s) state_nxt_s = OUTPUT; else state_nxt_s = IDLE;
      OUTPUT:  if (handshake_s) state_nxt_s = IDLE; else state_nxt_s = OUTPUT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode, taken from the next state so the flags can be registered.
  always_comb begin
    ready_nxt_s = 1'b0;
    valid_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE:    ready_nxt_s = 1'b1;
      OUTPUT:  valid_nxt_s = 1'b1;
      default: begin
        ready_nxt_s = 1'b0;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered handshake flags; ready stays low for as long as reset is held.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      ready_r <= ready_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Datapath: beat capture, per-mic summation, per-bin scaling and frame result.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      central_phase_r <= 16'sd0;
      central_mag_r   <= 16'sd0;
      for (int i = 0; i < NUM_PERIPH; i++) phase_r[i] <= 16'sd0;
      last_r     <= 1'b0;
      idx_r      <= {IW{1'b0}};
      sum_x_r    <= {SW{1'b0}};
      sum_y_r    <= {SW{1'b0}};
      acc_x_r    <= {AW{1'b0}};
      acc_y_r    <= {AW{1'b0}};
      bin_cnt_r  <= {BW{1'b0}};
      vector_r   <= 32'h0000_0000;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: if (accept_s) begin
          central_phase_r <= central_mic_in[31:16];
          central_mag_r   <= central_mic_in[15:0];
          for (int i = 0; i < NUM_PERIPH; i++) phase_r[i] <= peripheral_mics_in[32*i+16 +: 16];
          last_r  <= data_last_in;
          idx_r   <= {IW{1'b0}};
          sum_x_r <= {SW{1'b0}};
          sum_y_r <= {SW{1'b0}};
        end
        SUM: begin
          sum_x_r <= sum_x_r + term_x_s;
          sum_y_r <= sum_y_r + term_y_s;
          idx_r   <= (idx_r == LAST_IDX) ? idx_r : idx_r + IW'(1'b1);
        end
        SCALE: begin
          acc_x_r   <= acc_x_nxt_s;
          acc_y_r   <= acc_y_nxt_s;
          bin_cnt_r <= bin_nxt_s;
          if (close_s) begin
            vector_r   <= {sat16(acc_y_nxt_s), sat16(acc_x_nxt_s)};
            overflow_r <= !last_r;
          end
        end
        OUTPUT: if (handshake_s) begin
          acc_x_r    <= {AW{1'b0}};
          acc_y_r    <= {AW{1'b0}};
          bin_cnt_r  <= {BW{1'b0}};
          overflow_r <= 1'b0;
        end
        default: idx_r <= {IW{1'b0}};
      endcase
    end
  end

  assign data_ready_out   = ready_r;
  assign vector_valid_out = valid_r;
  assign vector_out       = vector_r;
  assign overflow_out     = overflow_r;

endmodule

// File: tb/tb_direction_accumulator.sv
// Directed bench for direction_accumulator: a default instance (a) and a MAX_BINS=4 instance (b)
// sharing clock, reset and mic data, each with its own handshakes.
module tb_direction_accumulator;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] central_mic_in;
  logic [95:0] peripheral_mics_in;
  logic        data_last_in;
  logic        valid_a, ready_a, vvalid_a, vready_a, ovf_a;
  logic        valid_b, ready_b, vvalid_b, vready_b, ovf_b;
  logic [31:0] vec_a, vec_b;
  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  direction_accumulator dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .central_mic_in(central_mic_in),
    .peripheral_mics_in(peripheral_mics_in), .data_valid_in(valid_a),
    .data_last_in(data_last_in), .data_ready_out(ready_a), .vector_out(vec_a),
    .vector_valid_out(vvalid_a), .vector_ready_in(vready_a), .overflow_out(ovf_a)
  );

  direction_accumulator #(.MAX_BINS(4)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .central_mic_in(central_mic_in),
    .peripheral_mics_in(peripheral_mics_in), .data_valid_in(valid_b),
    .data_last_in(data_last_in), .data_ready_out(ready_b), .vector_out(vec_b),
    .vector_valid_out(vvalid_b), .vector_ready_in(vready_b), .overflow_out(ovf_b)
  );

  task automatic drive_beat(input logic [31:0] cen, input logic [15:0] p0, p1, p2, input logic last);
    central_mic_in     = cen;
    peripheral_mics_in = {p2, 16'h0111, p1, 16'h0222, p0, 16'h0333};
    data_last_in       = last;
  endtask

  task automatic send_beat(input bit on_b, input logic [31:0] cen, input logic [15:0] p0, p1, p2,
                           input logic last, output bit ok);
    int n = 0;
    @(negedge clk_in);
    while (((on_b ? ready_b : ready_a) !== 1'b1) && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    ok = (n < 50);
    drive_beat(cen, p0, p1, p2, last);
    if (on_b) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk_in);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic get_vector(input bit on_b, output logic [31:0] v, output logic o, output bit got);
    int n = 0;
    got = 1'b0;
    v = 32'h0;
    o = 1'b0;
    @(negedge clk_in);
    while (((on_b ? vvalid_b : vvalid_a) !== 1'b1) && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    if ((on_b ? vvalid_b : vvalid_a) === 1'b1) begin
      got = 1'b1;
      v = on_b ? vec_b : vec_a;
      o = on_b ? ovf_b : ovf_a;
      if (on_b) vready_b = 1'b1; else vready_a = 1'b1;
      @(posedge clk_in);
      #1;
      vready_a = 1'b0;
      vready_b = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    tests++;
    if (ready_a !== 1'b0 || vvalid_a !== 1'b0 || vec_a !== 32'h0 || ovf_a !== 1'b0) begin
      $display("FAIL reset_hold: ready=%b valid=%b vec=%h ovf=%b, expected 0 0 00000000 0", ready_a, vvalid_a, vec_a, ovf_a);
      fails++;
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    tests++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1 || vvalid_b !== 1'b0) begin
      $display("FAIL reset_release: ready_a=%b ready_b=%b valid_b=%b, expected 1 1 0", ready_a, ready_b, vvalid_b);
      fails++;
    end
  endtask

  task automatic test_basic_latency;
    bit ok;
    int early = 0;
    send_beat(1'b0, 32'h0000_2000, 16'h1000, 16'h0000, 16'h0000, 1'b1, ok);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      if (vvalid_a !== 1'b0) early++;
    end
    @(negedge clk_in);
    tests++;
    if (!ok || early != 0 || vvalid_a !== 1'b1) begin
      $display("FAIL latency: early_valids=%0d valid_at_t+5=%b, expected 0 and 1", early, vvalid_a);
      fails++;
    end
    tests++;
    if (vec_a !== 32'h0080_0000 || ovf_a !== 1'b0) begin
      $display("FAIL basic_vector: vec=%h ovf=%b, expected 00800000 0", vec_a, ovf_a);
      fails++;
    end
    vready_a = 1'b1;
    @(posedge clk_in);
    #1;
    vready_a = 1'b0;
    @(negedge clk_in);
    tests++;
    if (vvalid_a !== 1'b0 || ready_a !== 1'b1) begin
      $display("FAIL basic_handshake: valid=%b ready=%b, expected 0 1", vvalid_a, ready_a);
      fails++;
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_v [4] = '{32'h0048_0000, 32'hFFB7_0000, 32'h0324_0000, 32'hFCDB_0000};
    logic [31:0] cen   [4] = '{32'h6000_2000, 32'hA000_2000, 32'h0000_2000, 32'h0000_2000};
    logic [15:0] p0    [4] = '{16'hA000, 16'h6000, 16'h6488, 16'h6489};
    logic [15:0] po    [4] = '{16'h6000, 16'hA000, 16'h0000, 16'h0000};
    for (int k = 0; k < 4; k++) begin
      bit ok, got;
      logic [31:0] v;
      logic o;
      send_beat(1'b0, cen[k], p0[k], po[k], po[k], 1'b1, ok);
      get_vector(1'b0, v, o, got);
      tests++;
      if (!ok || !got || v !== exp_v[k] || o !== 1'b0) begin
        $display("FAIL wrap_%0d: vec=%h ovf=%b got=%0d, expected %h 0", k, v, o, got, exp_v[k]);
        fails++;
      end
    end
  endtask

  task automatic test_xy_mix;
    bit ok, got;
    logic [31:0] v;
    logic o;
    send_beat(1'b0, 32'h0000_2000, 16'h0000, 16'h0800, 16'h0400, 1'b1, ok);
    get_vector(1'b0, v, o, got);
    tests++;
    if (!ok || !got || v !== 32'hFFA0_FFE0 || o !== 1'b0) begin
      $display("FAIL xy_mix: vec=%h ovf=%b got=%0d, expected ffa0ffe0 0", v, o, got);
      fails++;
    end
    send_beat(1'b0, 32'h0000_E000, 16'h1000, 16'h0000, 16'h0000, 1'b1, ok);
    get_vector(1'b0, v, o, got);
    tests++;
    if (!ok || !got || v !== 32'hFF80_0000 || o !== 1'b0) begin
      $display("FAIL negative_mag: vec=%h ovf=%b got=%0d, expected ff800000 0", v, o, got);
      fails++;
    end
  endtask

  task automatic test_multi_bin;
    bit ok1, ok2, got;
    logic [31:0] v;
    logic o;
    int early = 0;
    send_beat(1'b0, 32'h0000_2000, 16'h1000, 16'h0000, 16'h0000, 1'b0, ok1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      if (vvalid_a !== 1'b0) early++;
    end
    tests++;
    if (early != 0) begin
      $display("FAIL multi_bin_early: valid seen %0d cycles after a last=0 beat, expected 0", early);
      fails++;
    end
    send_beat(1'b0, 32'h0000_2000, 16'h1000, 16'h0000, 16'h0000, 1'b1, ok2);
    get_vector(1'b0, v, o, got);
    tests++;
    if (!ok1 || !ok2 || !got || v !== 32'h0100_0000 || o !== 1'b0) begin
      $display("FAIL multi_bin: vec=%h ovf=%b got=%0d, expected 01000000 0", v, o, got);
      fails++;
    end
  endtask

  task automatic test_ready_preheld;
    bit ok;
    int hi = 0;
    vready_a = 1'b1;
    send_beat(1'b0, 32'h0000_2000, 16'h1000, 16'h0000, 16'h0000, 1'b1, ok);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      if (vvalid_a === 1'b1) hi++;
    end
    vready_a = 1'b0;
    tests++;
    if (!ok || hi != 1) begin
      $display("FAIL ready_preheld: valid high for %0d cycles, expected 1", hi);
      fails++;
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int n = 0;
    int bad_vec = 0;
    int bad_rdy = 0;
    int extra = 0;
    send_beat(1'b0, 32'h6000_2000, 16'hA000, 16'h6000, 16'h6000, 1'b1, ok);
    @(negedge clk_in);
    while (vvalid_a !== 1'b1 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      drive_beat(32'h1234_7FFF, 16'h3000 + 16'(k), 16'h5000, 16'h7000, 1'b1);
      valid_a = 1'b1;
      @(negedge clk_in);
      if (vec_a !== 32'h0048_0000 || vvalid_a !== 1'b1) bad_vec++;
      if (ready_a !== 1'b0) bad_rdy++;
    end
    tests++;
    if (!ok || n >= 40 || bad_vec != 0) begin
      $display("FAIL backpressure_hold: %0d unstable cycles, last vec=%h, expected 00480000 held", bad_vec, vec_a);
      fails++;
    end
    tests++;
    if (bad_rdy != 0) begin
      $display("FAIL backpressure_ready: ready high in %0d cycles, expected 0", bad_rdy);
      fails++;
    end
    valid_a = 1'b0;
    vready_a = 1'b1;
    @(posedge clk_in);
    #1;
    vready_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      if (vvalid_a !== 1'b0 || ready_a !== 1'b1) extra++;
    end
    tests++;
    if (extra != 0) begin
      $display("FAIL backpressure_release: %0d cycles not idle after handshake, expected 0", extra);
      fails++;
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok1, ok2, got;
    logic [31:0] v;
    logic o;
    send_beat(1'b0, 32'h1234_7FFF, 16'h5555, 16'h6666, 16'h7777, 1'b1, ok1);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    tests++;
    if (ready_a !== 1'b0 || vvalid_a !== 1'b0 || vec_a !== 32'h0 || ovf_a !== 1'b0) begin
      $display("FAIL mid_reset: ready=%b valid=%b vec=%h ovf=%b, expected 0 0 00000000 0", ready_a, vvalid_a, vec_a, ovf_a);
      fails++;
    end
    send_beat(1'b0, 32'h0000_2000, 16'h1000, 16'h0000, 16'h0000, 1'b1, ok2);
    get_vector(1'b0, v, o, got);
    tests++;
    if (!ok1 || !ok2 || !got || v !== 32'h0080_0000 || o !== 1'b0) begin
      $display("FAIL after_reset: vec=%h ovf=%b got=%0d, expected 00800000 0", v, o, got);
      fails++;
    end
  endtask

  task automatic test_overflow;
    bit ok;
    bit all_ok = 1'b1;
    bit got;
    logic [31:0] v;
    logic o;
    for (int k = 0; k < 4; k++) begin
      send_beat(1'b1, 32'h0000_7FFF, 16'h6488, 16'h9B78, 16'h9B78, 1'b0, ok);
      all_ok &= ok;
    end
    get_vector(1'b1, v, o, got);
    tests++;
    if (!all_ok || !got || v !== 32'h7FFF_0000 || o !== 1'b1) begin
      $display("FAIL overflow_pos: vec=%h ovf=%b got=%0d, expected 7fff0000 1", v, o, got);
      fails++;
    end
    for (int k = 0; k < 4; k++) begin
      send_beat(1'b1, 32'h0000_7FFF, 16'h9B78, 16'h6488, 16'h6488, 1'b0, ok);
      all_ok &= ok;
    end
    get_vector(1'b1, v, o, got);
    tests++;
    if (!all_ok || !got || v !== 32'h8000_0000 || o !== 1'b1) begin
      $display("FAIL overflow_neg: vec=%h ovf=%b got=%0d, expected 80000000 1", v, o, got);
      fails++;
    end
    send_beat(1'b1, 32'h0000_2000, 16'h1000, 16'h0000, 16'h0000, 1'b1, ok);
    get_vector(1'b1, v, o, got);
    tests++;
    if (!ok || !got || v !== 32'h0080_0000 || o !== 1'b0) begin
      $display("FAIL overflow_cleared: vec=%h ovf=%b got=%0d, expected 00800000 0", v, o, got);
      fails++;
    end
  endtask

  initial begin
    rst_in = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    vready_a = 1'b0;
    vready_b = 1'b0;
    drive_beat(32'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    test_reset();
    test_basic_latency();
    test_wrap();
    test_xy_mix();
    test_multi_bin();
    test_ready_preheld();
    test_backpressure();
    test_reset_mid_frame();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
